// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Debug readout engine. On a start pulse it walks register IDs 0..NUM_REGS-1
//   through one combinational register-file read port and streams a frame over a
//   valid/ready byte interface: HDR_BYTE, then 4 little-endian bytes per register,
//   then the XOR of all data bytes (the header is not included in the checksum).
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   start, abort        begin a dump (IDLE only) / cancel a dump in progress
//   busy, done          dump in progress / 1-cycle pulse after checksum accepted
//   rd_id, rd_data      register-file read port (rd_data valid same cycle)
//   tx_data, tx_valid   byte stream to transmitter, accepted on tx_valid & tx_ready
//   tx_ready
module regfile_dump_reader #(
  parameter int          NUM_REGS = 32,
  parameter int          ID_W     = 5,
  parameter int          DATA_W   = 32,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ID_W-1:0]   rd_id,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LATCH, S_SEND, S_CSUM} state_e;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REGS - 1);

  state_e          state_q, state_d;
  logic [ID_W-1:0] index_q, index_d;
  logic [ID_W-1:0] rd_id_q, rd_id_d;
  logic [1:0]      byte_q, byte_d;
  logic [7:0]      checksum_q, checksum_d;
  logic [31:0]     shift_q, shift_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic hs;
  logic kill;

  assign hs   = tx_valid_q & tx_ready;
  // abort only acts on a dump in progress; in IDLE it is a no-op
  assign kill = abort & (state_q != S_IDLE);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      index_q    <= '0;
      rd_id_q    <= '0;
      byte_q     <= '0;
      checksum_q <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      rd_id_q    <= rd_id_d;
      byte_q     <= byte_d;
      checksum_q <= checksum_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start && !abort) state_d = S_HDR;
        S_HDR:   if (hs) state_d = S_LATCH;
        S_LATCH: state_d = S_SEND;
        S_SEND:  if (hs && byte_q == 2'd3)
                   state_d = (index_q == LAST_ID) ? S_CSUM : S_LATCH;
        S_CSUM:  if (hs) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // output / datapath logic; every registered output is computed for the
  // state being entered so it is valid from the first cycle of that state
  always_comb begin
    index_d    = index_q;
    rd_id_d    = rd_id_q;
    byte_d     = byte_q;
    checksum_d = checksum_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: if (start && !abort) begin
        busy_d     = 1'b1;
        index_d    = '0;
        checksum_d = '0;
        byte_d     = '0;
        tx_valid_d = 1'b1;
        tx_data_d  = HDR_BYTE;
      end
      S_HDR: if (hs) begin
        tx_valid_d = 1'b0;
        rd_id_d    = index_q;
      end
      S_LATCH: begin
        // rd_id has been stable all cycle, so rd_data is the value for index_q
        shift_d    = 32'(rd_data);
        tx_data_d  = rd_data[7:0];
        tx_valid_d = 1'b1;
        byte_d     = '0;
      end
      S_SEND: if (hs) begin
        checksum_d = checksum_q ^ tx_data_q;
        byte_d     = byte_q + 2'd1;
        shift_d    = shift_q >> 8;
        if (byte_q != 2'd3) begin
          tx_data_d = shift_q[15:8];
        end else if (index_q == LAST_ID) begin
          tx_data_d = checksum_q ^ tx_data_q;
        end else begin
          tx_valid_d = 1'b0;
          index_d    = index_q + 1'b1;
          rd_id_d    = index_q + 1'b1;
        end
      end
      S_CSUM: if (hs) begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
      end
      default: ;
    endcase
    if (kill) begin
      tx_valid_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_id    = rd_id_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a 32-register and a 4-register instance, each
// fed by a behavioural register file; expected frames come from a byte-list model.
module tb_regfile_dump_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 32-register instance
  logic        start_a = 0, abort_a = 0, tx_ready_a = 0;
  logic        busy_a, done_a, tx_valid_a;
  logic [4:0]  rd_id_a;
  logic [31:0] rd_data_a;
  logic [7:0]  tx_data_a;
  logic [31:0] regs_a [32];
  assign rd_data_a = (rd_id_a == 5'd0) ? 32'h0 : regs_a[rd_id_a];

  // 4-register instance
  logic        start_b = 0, abort_b = 0, tx_ready_b = 0;
  logic        busy_b, done_b, tx_valid_b;
  logic [4:0]  rd_id_b;
  logic [31:0] rd_data_b;
  logic [7:0]  tx_data_b;
  logic [31:0] regs_b [32];
  assign rd_data_b = (rd_id_b == 5'd0) ? 32'h0 : regs_b[rd_id_b];

  regfile_dump_reader #(.NUM_REGS(32)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .rd_id(rd_id_a), .rd_data(rd_data_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a));

  regfile_dump_reader #(.NUM_REGS(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .rd_id(rd_id_b), .rd_data(rd_data_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b));

  // byte collectors: a handshake seen at the negedge completes at the next posedge
  logic [7:0] q_a[$], q_b[$], exp_q[$];
  always @(negedge clk) begin
    if (!reset && tx_valid_a && tx_ready_a) q_a.push_back(tx_data_a);
    if (!reset && tx_valid_b && tx_ready_b) q_b.push_back(tx_data_b);
  end

  // reference frame: header, each register's bytes LSB first, XOR of data bytes
  task automatic build_exp(input bit sel, input int n);
    logic [7:0]  cs;
    logic [31:0] w;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? 32'h0 : (sel ? regs_b[i] : regs_a[i]);
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done_a); end
    total++; if (tx_valid_a !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%0b want=0", tx_valid_a); end
    total++; if (tx_data_a !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data_a); end
    total++; if (rd_id_a !== 5'd0) begin bad++; $display("FAIL reset_rd_id got=%0d want=0", rd_id_a); end
    total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy_b got=%0b want=0", busy_b); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_frame;
    int dcyc;
    for (int i = 0; i < 32; i++) regs_a[i] = 32'h1000_0000 + i;
    tx_ready_a = 1'b1;
    q_a.delete();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL ff_busy_after_start got=%0b want=1", busy_a); end
    dcyc = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) begin dcyc = c; break; end
    end
    total++; if (dcyc != 162) begin bad++; $display("FAIL ff_done_cycle got=%0d want=162", dcyc); end
    build_exp(1'b0, 32);
    total++; if (q_a.size() != 130) begin bad++; $display("FAIL ff_len got=%0d want=130", q_a.size()); end
    for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
      total++; if (q_a[i] !== exp_q[i]) begin bad++; $display("FAIL ff_byte[%0d] got=%h want=%h", i, q_a[i], exp_q[i]); end
    end
    total++; if (q_a.size() == 0 || q_a[q_a.size()-1] !== 8'h10) begin bad++; $display("FAIL ff_checksum want=10"); end
    @(posedge clk); #1;
    total++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin bad++; $display("FAIL ff_after_done done=%0b busy=%0b want=0/0", done_a, busy_a); end
  endtask

  task automatic test_random_ready;
    int dcyc;
    bit prev_hold;
    logic [7:0] prev_data;
    for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
    q_a.delete();
    tx_ready_a = 1'b0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    prev_hold = 0;
    prev_data = 8'h00;
    dcyc = -1;
    for (int c = 1; c <= 3000; c++) begin
      if (prev_hold) begin
        total++;
        if (tx_valid_a !== 1'b1 || tx_data_a !== prev_data) begin
          bad++; $display("FAIL rr_hold c=%0d valid=%0b data=%h want=1/%h", c, tx_valid_a, tx_data_a, prev_data);
        end
      end
      if (done_a === 1'b1) begin dcyc = c; break; end
      tx_ready_a = ($urandom_range(0, 9) < 3);
      prev_hold = tx_valid_a && !tx_ready_a;
      prev_data = tx_data_a;
      @(posedge clk); #1;
    end
    tx_ready_a = 1'b1;
    total++; if (dcyc < 0) begin bad++; $display("FAIL rr_timeout got=no_done want=done"); end
    build_exp(1'b0, 32);
    total++; if (q_a.size() != exp_q.size()) begin bad++; $display("FAIL rr_len got=%0d want=%0d", q_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
      total++; if (q_a[i] !== exp_q[i]) begin bad++; $display("FAIL rr_byte[%0d] got=%h want=%h", i, q_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_ignored;
    int ndone;
    tx_ready_a = 1'b1;
    q_a.delete();
    start_a = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    for (int c = 1; c <= 400; c++) begin
      start_a = (c < 150) && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      if (done_a === 1'b1) ndone++;
    end
    start_a = 1'b0;
    total++; if (ndone != 1) begin bad++; $display("FAIL si_done_count got=%0d want=1", ndone); end
    build_exp(1'b0, 32);
    total++; if (q_a.size() != 130) begin bad++; $display("FAIL si_len got=%0d want=130", q_a.size()); end
    // second frame after done must be identical
    q_a.delete();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) begin ndone = c; break; end
    end
    total++; if (ndone != 162) begin bad++; $display("FAIL si_second_done got=%0d want=162", ndone); end
    total++; if (q_a.size() != exp_q.size()) begin bad++; $display("FAIL si_second_len got=%0d want=%0d", q_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
      total++; if (q_a[i] !== exp_q[i]) begin bad++; $display("FAIL si_byte[%0d] got=%h want=%h", i, q_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort;
    int dcyc;
    bit seen;
    logic [31:0] w5;
    tx_ready_a = 1'b1;
    // abort in IDLE does nothing
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    total++; if (busy_a !== 1'b0 || tx_valid_a !== 1'b0) begin bad++; $display("FAIL ab_idle busy=%0b valid=%0b want=0/0", busy_a, tx_valid_a); end
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    // register 5, byte b2 is on the bus after edge 2+5*5+2
    repeat (29) @(posedge clk);
    #1;
    w5 = regs_a[5];
    total++; if (tx_valid_a !== 1'b1 || tx_data_a !== w5[23:16]) begin bad++; $display("FAIL ab_pre valid=%0b data=%h want=1/%h", tx_valid_a, tx_data_a, w5[23:16]); end
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    total++; if (tx_valid_a !== 1'b0) begin bad++; $display("FAIL ab_tx_valid got=%0b want=0", tx_valid_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL ab_busy got=%0b want=0", busy_a); end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done_a !== 1'b0 || tx_valid_a !== 1'b0) seen = 1;
      @(posedge clk); #1;
    end
    total++; if (seen) begin bad++; $display("FAIL ab_quiet got=activity want=none"); end
    q_a.delete();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    dcyc = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) begin dcyc = c; break; end
    end
    total++; if (dcyc != 162) begin bad++; $display("FAIL ab_restart_done got=%0d want=162", dcyc); end
    build_exp(1'b0, 32);
    total++; if (q_a.size() != exp_q.size()) begin bad++; $display("FAIL ab_len got=%0d want=%0d", q_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
      total++; if (q_a[i] !== exp_q[i]) begin bad++; $display("FAIL ab_byte[%0d] got=%h want=%h", i, q_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_async_reset;
    bit seen;
    tx_ready_a = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    total++; if (busy_a !== 1'b1 || tx_valid_a !== 1'b1) begin bad++; $display("FAIL ar_pre busy=%0b valid=%0b want=1/1", busy_a, tx_valid_a); end
    #2 reset = 1'b1;
    #1;
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL ar_busy got=%0b want=0", busy_a); end
    total++; if (tx_valid_a !== 1'b0) begin bad++; $display("FAIL ar_tx_valid got=%0b want=0", tx_valid_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL ar_done got=%0b want=0", done_a); end
    total++; if (rd_id_a !== 5'd0) begin bad++; $display("FAIL ar_rd_id got=%0d want=0", rd_id_a); end
    @(posedge clk); #3;
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (busy_a !== 1'b0 || tx_valid_a !== 1'b0 || done_a !== 1'b0) seen = 1;
    end
    total++; if (seen) begin bad++; $display("FAIL ar_idle got=activity want=idle"); end
  endtask

  task automatic test_num4;
    int dcyc;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 32; i++) regs_b[i] = (pass == 0) ? 32'hDEADBEEF : $urandom;
      tx_ready_b = 1'b1;
      q_b.delete();
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      dcyc = -1;
      for (int c = 1; c <= 2000; c++) begin
        if (pass == 1) tx_ready_b = ($urandom_range(0, 1) == 0);
        @(posedge clk); #1;
        if (done_b === 1'b1) begin dcyc = c; break; end
      end
      tx_ready_b = 1'b1;
      if (pass == 0) begin
        total++; if (dcyc != 22) begin bad++; $display("FAIL n4_done_cycle got=%0d want=22", dcyc); end
      end else begin
        total++; if (dcyc < 0) begin bad++; $display("FAIL n4_timeout got=no_done want=done"); end
      end
      build_exp(1'b1, 4);
      total++; if (q_b.size() != 18) begin bad++; $display("FAIL n4_len pass=%0d got=%0d want=18", pass, q_b.size()); end
      for (int i = 0; i < exp_q.size() && i < q_b.size(); i++) begin
        total++; if (q_b[i] !== exp_q[i]) begin bad++; $display("FAIL n4_byte[%0d] pass=%0d got=%h want=%h", i, pass, q_b[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin regs_a[i] = 32'h0; regs_b[i] = 32'h0; end
    test_reset();
    test_full_frame();
    test_random_ready();
    test_start_ignored();
    test_abort();
    test_async_reset();
    test_num4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
